// File: rtl/result_writer.sv
// -----------------------------------------------------------------------------
// result_writer
//
// Purpose:
//   Tail-end capture buffer for the convolution datapath. After a start pulse
//   it accepts one frame of DEPTH pixels over a valid/ready stream and writes
//   them to sequential addresses 0..DEPTH-1 of an internal frame buffer. When
//   the frame is complete it raises done. A registered readback port lets
//   downstream logic or a bench dump the captured frame.
//
// Ports:
//   clk       in   1       system clock, rising edge
//   reset     in   1       asynchronous, active-low reset
//   start     in   1       one-cycle pulse; arms a new frame capture
//                          (ignored while a capture is in progress)
//   in_valid  in   1       input pixel valid
//   in_data   in   DATA_W  input pixel value, stored unmodified
//   in_ready  out  1       a pixel can be accepted this cycle (WRITE state)
//   busy      out  1       capture in progress (WRITE state)
//   done      out  1       frame complete; held until the next start
//   overflow  out  1       sticky: in_valid seen while in_ready was low
//   wr_count  out  ADDR_W  pixels written in the current frame (ends at DEPTH)
//   rd_addr   in   ADDR_W  readback address
//   rd_data   out  DATA_W  readback data, one cycle after rd_addr;
//                          zero for addresses >= DEPTH
// -----------------------------------------------------------------------------
module result_writer #(
    parameter int DEPTH  = 540,
    parameter int DATA_W = 9,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] wr_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Index width actually needed to address the frame buffer. It is never
    // wider than ADDR_W because 2^ADDR_W >= DEPTH.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Highest valid buffer address, expressed at address width so that all
    // comparisons below stay width-matched.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // -------------------------------------------------------------------------
    // State and storage
    // -------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wr_count;
    logic              r_overflow;
    logic [DATA_W-1:0] r_rd_data;

    // Frame buffer: written only on accepted transfers and never reset, so it
    // maps onto block RAM with a registered read port.
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic              w_in_ready;
    logic              w_xfer;
    logic              w_start_take;
    logic              w_last;
    logic              w_drop;
    logic              w_rd_in_range;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;

    assign w_in_ready    = (r_state == ST_WRITE);
    assign w_xfer        = in_valid && w_in_ready;

    // start is only honoured from IDLE or DONE; a start pulse while a frame
    // is being captured has no effect.
    assign w_start_take  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    assign w_last        = (r_wr_count == LAST_ADDR);

    // A pixel offered while not ready is dropped and flagged.
    assign w_drop        = in_valid && !w_in_ready;

    assign w_rd_in_range = (rd_addr <= LAST_ADDR);

    // Low address bits are sufficient: writes only happen while
    // wr_count <= DEPTH-1, and reads are gated by w_rd_in_range.
    assign w_wr_idx      = r_wr_count[IDX_W-1:0];
    assign w_rd_idx      = rd_addr[IDX_W-1:0];

    // -------------------------------------------------------------------------
    // Capture FSM and write counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wr_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_take) begin
                        r_state    <= ST_WRITE;
                        r_wr_count <= '0;
                    end
                end
                ST_WRITE: begin
                    if (w_xfer) begin
                        // The counter deliberately runs to DEPTH on the last
                        // transfer so it reports the full frame size.
                        r_wr_count <= r_wr_count + 1'b1;
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wr_count <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sticky overflow flag
    // The start clear wins over a same-cycle drop, so a start issued together
    // with in_valid leaves overflow low.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_start_take) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Frame buffer write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mem[w_wr_idx] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Registered readback port
    // A same-address read and write in one cycle returns the old contents,
    // because the read samples the array before the write lands.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (w_rd_in_range) begin
            r_rd_data <= r_mem[w_rd_idx];
        end else begin
            r_rd_data <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready = w_in_ready;
    assign busy     = (r_state == ST_WRITE);
    assign done     = (r_state == ST_DONE);
    assign overflow = r_overflow;
    assign wr_count = r_wr_count;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_result_writer.sv
// -----------------------------------------------------------------------------
// tb_result_writer
//
// Directed testbench for result_writer. Each scenario task drives its own
// stimulus and compares the outputs against hand-computed expected values.
// Inputs change 1 ns after a rising edge and outputs are sampled at that
// point too, so every sample reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_result_writer;

    localparam int DEPTH  = 540;
    localparam int DATA_W = 9;
    localparam int ADDR_W = 11;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W-1:0] wr_count;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    int tests_run    = 0;
    int tests_failed = 0;

    result_writer #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .busy    (busy),
        .done    (done),
        .overflow(overflow),
        .wr_count(wr_count),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance one clock edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a readback address and return the data one cycle later.
    task automatic read_word(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data);
        rd_addr = addr;
        tick();
        data = rd_data;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_addr  = '0;
        tick();
        tick();
        tests_run++;
        if ({in_ready, busy, done, overflow} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got ready/busy/done/ovf=%b required 0000",
                     {in_ready, busy, done, overflow});
        end
        tests_run++;
        if (wr_count !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_wr_count: got %0d required 0", wr_count);
        end
        tests_run++;
        if (rd_data !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_rd_data: got %0d required 0", rd_data);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if ({in_ready, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_not_ready: got ready/busy=%b required 00", {in_ready, busy});
        end
        $display("[TB] test_reset done");
    endtask

    // -------------------------------------------------------------------------
    // 540 back-to-back pixels, value = index mod 512.
    task automatic test_full_frame();
        logic [DATA_W-1:0] d;
        int ready_errs;
        ready_errs = 0;
        pulse_start();
        tests_run++;
        if ({busy, in_ready, done} !== 3'b110) begin
            tests_failed++;
            $display("FAIL start_to_write: got busy/ready/done=%b required 110", {busy, in_ready, done});
        end
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 9'(i);
            if (in_ready !== 1'b1) ready_errs++;
            tick();
            if (i == 0) begin
                tests_run++;
                if (wr_count !== 11'd1) begin
                    tests_failed++;
                    $display("FAIL first_count: got %0d required 1", wr_count);
                end
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (ready_errs != 0) begin
            tests_failed++;
            $display("FAIL ready_throughout: got %0d not-ready cycles required 0", ready_errs);
        end
        tests_run++;
        if ({done, busy, in_ready} !== 3'b100) begin
            tests_failed++;
            $display("FAIL frame_done: got done/busy/ready=%b required 100", {done, busy, in_ready});
        end
        tests_run++;
        if (wr_count !== 11'd540) begin
            tests_failed++;
            $display("FAIL frame_count: got %0d required 540", wr_count);
        end
        read_word(11'd0, d);
        tests_run++;
        if (d !== 9'd0) begin
            tests_failed++;
            $display("FAIL rd_addr0: got %0d required 0", d);
        end
        read_word(11'd1, d);
        tests_run++;
        if (d !== 9'd1) begin
            tests_failed++;
            $display("FAIL rd_addr1: got %0d required 1", d);
        end
        read_word(11'd539, d);
        tests_run++;
        if (d !== 9'd27) begin
            tests_failed++;
            $display("FAIL rd_addr539: got %0d required 27", d);
        end
        read_word(11'd512, d);
        tests_run++;
        if (d !== 9'd0) begin
            tests_failed++;
            $display("FAIL rd_addr512: got %0d required 0", d);
        end
        $display("[TB] test_full_frame done");
    endtask

    // -------------------------------------------------------------------------
    // A 541st pixel after done is dropped and flagged.
    task automatic test_done_overflow();
        logic [DATA_W-1:0] d;
        in_valid = 1'b1;
        in_data  = 9'h1FF;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({overflow, done} !== 2'b11) begin
            tests_failed++;
            $display("FAIL done_overflow: got ovf/done=%b required 11", {overflow, done});
        end
        tests_run++;
        if (wr_count !== 11'd540) begin
            tests_failed++;
            $display("FAIL done_overflow_count: got %0d required 540", wr_count);
        end
        read_word(11'd539, d);
        tests_run++;
        if (d !== 9'd27) begin
            tests_failed++;
            $display("FAIL done_overflow_mem539: got %0d required 27", d);
        end
        $display("[TB] test_done_overflow done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_oob_readback();
        logic [DATA_W-1:0] d;
        read_word(11'd538, d);
        tests_run++;
        if (d !== 9'd26) begin
            tests_failed++;
            $display("FAIL rd_addr538: got %0d required 26", d);
        end
        read_word(11'd540, d);
        tests_run++;
        if (d !== 9'd0) begin
            tests_failed++;
            $display("FAIL rd_addr540: got %0d required 0", d);
        end
        read_word(11'd3, d);
        read_word(11'd2047, d);
        tests_run++;
        if (d !== 9'd0) begin
            tests_failed++;
            $display("FAIL rd_addr2047: got %0d required 0", d);
        end
        $display("[TB] test_oob_readback done");
    endtask

    // -------------------------------------------------------------------------
    // start and in_valid together in DONE: start wins, pixel dropped,
    // overflow (set before) ends up cleared.
    task automatic test_start_with_valid();
        logic [DATA_W-1:0] d;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 9'h0AA;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if ({busy, done, overflow} !== 3'b100) begin
            tests_failed++;
            $display("FAIL start_valid_flags: got busy/done/ovf=%b required 100", {busy, done, overflow});
        end
        tests_run++;
        if (wr_count !== 11'd0) begin
            tests_failed++;
            $display("FAIL start_valid_count: got %0d required 0", wr_count);
        end
        read_word(11'd0, d);
        tests_run++;
        if (d !== 9'd0) begin
            tests_failed++;
            $display("FAIL start_valid_mem0: got %0h required 0", d);
        end
        $display("[TB] test_start_with_valid done");
    endtask

    // -------------------------------------------------------------------------
    // Gapped stream inside the frame armed above; a start during WRITE is
    // issued on one idle cycle and must be ignored.
    task automatic test_gapped();
        logic [DATA_W-1:0] vals [4];
        logic [ADDR_W-1:0] exp_cnt [8];
        logic [DATA_W-1:0] d;
        vals = '{9'h1AB, 9'h055, 9'h123, 9'h0F0};
        exp_cnt = '{11'd1, 11'd1, 11'd2, 11'd2, 11'd3, 11'd3, 11'd4, 11'd4};
        for (int c = 0; c < 8; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = (c % 2 == 0) ? vals[c/2] : 9'h1EE;
            start    = (c == 3);
            tick();
            tests_run++;
            if (wr_count !== exp_cnt[c]) begin
                tests_failed++;
                $display("FAIL gapped_count_c%0d: got %0d required %0d", c, wr_count, exp_cnt[c]);
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        tests_run++;
        if ({busy, overflow} !== 2'b10) begin
            tests_failed++;
            $display("FAIL gapped_flags: got busy/ovf=%b required 10", {busy, overflow});
        end
        for (int a = 0; a < 4; a++) begin
            read_word(11'(a), d);
            tests_run++;
            if (d !== vals[a]) begin
                tests_failed++;
                $display("FAIL gapped_mem%0d: got %h required %h", a, d, vals[a]);
            end
        end
        // Address 4 untouched: still holds the previous frame's value.
        read_word(11'd4, d);
        tests_run++;
        if (d !== 9'd4) begin
            tests_failed++;
            $display("FAIL gapped_mem4: got %0d required 4", d);
        end
        $display("[TB] test_gapped done");
    endtask

    // -------------------------------------------------------------------------
    // Reset back to IDLE, then in_valid in IDLE.
    task automatic test_idle_overflow();
        logic [DATA_W-1:0] d;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({busy, in_ready, wr_count} !== {2'b00, 11'd0}) begin
            tests_failed++;
            $display("FAIL async_reset_write: got busy/ready=%b count=%0d required 00/0",
                     {busy, in_ready}, wr_count);
        end
        tick();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data  = 9'h0FF;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({overflow, in_ready, busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL idle_overflow: got ovf/ready/busy=%b required 100", {overflow, in_ready, busy});
        end
        tests_run++;
        if (wr_count !== 11'd0) begin
            tests_failed++;
            $display("FAIL idle_overflow_count: got %0d required 0", wr_count);
        end
        read_word(11'd0, d);
        tests_run++;
        if (d !== 9'h1AB) begin
            tests_failed++;
            $display("FAIL idle_overflow_mem0: got %h required 1ab", d);
        end
        pulse_start();
        tests_run++;
        if ({overflow, busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL start_clears_overflow: got ovf/busy=%b required 01", {overflow, busy});
        end
        $display("[TB] test_idle_overflow done");
    endtask

    // -------------------------------------------------------------------------
    // 100 pixels, reset mid-frame, then a full new frame (value = 7*i+5 mod 512).
    task automatic test_reset_midframe();
        logic [DATA_W-1:0] d;
        int data_errs;
        data_errs = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 9'h100 | 9'(i);
            tick();
        end
        in_valid = 1'b0;
        tests_run++;
        if (wr_count !== 11'd100) begin
            tests_failed++;
            $display("FAIL mid_count: got %0d required 100", wr_count);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({busy, in_ready, done, wr_count, rd_data} !== {3'b000, 11'd0, 9'd0}) begin
            tests_failed++;
            $display("FAIL mid_async_reset: got busy/ready/done=%b count=%0d rd=%0d required 000/0/0",
                     {busy, in_ready, done}, wr_count, rd_data);
        end
        tick();
        reset = 1'b1;
        tick();
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 9'(i * 7 + 5);
            tick();
        end
        in_valid = 1'b0;
        tests_run++;
        if ({done, busy} !== 2'b10 || wr_count !== 11'd540) begin
            tests_failed++;
            $display("FAIL refill_done: got done/busy=%b count=%0d required 10/540", {done, busy}, wr_count);
        end
        read_word(11'd99, d);
        tests_run++;
        if (d !== 9'd186) begin
            tests_failed++;
            $display("FAIL refill_mem99: got %0d required 186", d);
        end
        read_word(11'd539, d);
        tests_run++;
        if (d !== 9'd194) begin
            tests_failed++;
            $display("FAIL refill_mem539: got %0d required 194", d);
        end
        for (int a = 0; a < DEPTH; a++) begin
            read_word(11'(a), d);
            if (d !== 9'(a * 7 + 5)) data_errs++;
        end
        tests_run++;
        if (data_errs != 0) begin
            tests_failed++;
            $display("FAIL refill_full_dump: got %0d wrong words required 0", data_errs);
        end
        $display("[TB] test_reset_midframe done");
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_full_frame();
        test_done_overflow();
        test_oob_readback();
        test_start_with_valid();
        test_gapped();
        test_idle_overflow();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
